// File: rtl/efuse_prog_ctrl_if.sv
// efuse_prog_ctrl_if: request, macro and status signals of the eFuse sequencer.
interface efuse_prog_ctrl_if #(
   parameter int NBITS = 32,
   parameter int AW    = 5
);
   logic             start_i;
   logic             prog_mode_i;
   logic [7:0]       prog_key_i;
   logic             abort_i;
   logic [NBITS-1:0] fuse_din_i;
   logic             efuse_q_i;
   logic             efuse_vddq_en_o;
   logic             efuse_csb_o;
   logic             efuse_pgm_o;
   logic             efuse_strobe_o;
   logic [AW-1:0]    efuse_a_o;
   logic [NBITS-1:0] fuse_dout_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   modport slave (
      input  start_i, prog_mode_i, prog_key_i, abort_i, fuse_din_i, efuse_q_i,
      output efuse_vddq_en_o, efuse_csb_o, efuse_pgm_o, efuse_strobe_o, efuse_a_o,
             fuse_dout_o, busy_o, done_o, err_o
   );
   modport master (
      output start_i, prog_mode_i, prog_key_i, abort_i, fuse_din_i, efuse_q_i,
      input  efuse_vddq_en_o, efuse_csb_o, efuse_pgm_o, efuse_strobe_o, efuse_a_o,
             fuse_dout_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/efuse_prog_ctrl.sv
// efuse_prog_ctrl: key-protected eFuse program/read sequencer with registered macro controls.
module efuse_prog_ctrl #(
   parameter int         NBITS      = 32,
   parameter int         AW         = 5,
   parameter int         PGM_CYCLES = 10,
   parameter int         PWR_CYCLES = 4,
   parameter logic [7:0] PROG_KEY   = 8'hA5
) (
   input logic clk_i,
   input logic rst_ni,
   efuse_prog_ctrl_if.slave bus
);
   localparam int CMAX = PGM_CYCLES > PWR_CYCLES ? PGM_CYCLES : PWR_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   typedef enum logic [3:0] {
      IDLE, PWR_UP, PGM_BIT, PGM_GAP, SKIP, PWR_DN, RD_SETUP, RD_STROBE, RD_CAP, DONE
   } state_e;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    a_q, a_d, a_inc;
   logic [NBITS-1:0] din_q, din_d, shadow_q, shadow_d, dout_q, dout_d;
   logic             err_q, err_d, done_q, vddq_q, csb_q, pgm_q, strobe_q, busy_q;
   logic             nack, last_bit, pwr_last, pgm_last;
   assign a_inc    = a_q + 1'b1;
   assign last_bit = a_q == AW'(NBITS - 1);
   assign pwr_last = cnt_q == CW'(PWR_CYCLES - 1);
   assign pgm_last = cnt_q == CW'(PGM_CYCLES - 1);
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      din_d    = din_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      err_d    = err_q;
      nack     = 1'b0;
      case (state_q)
         IDLE: if (bus.start_i) begin
            err_d = 1'b0;
            din_d = bus.fuse_din_i;
            a_d   = '0;
            if (!bus.prog_mode_i) state_d = RD_SETUP;
            else if (bus.prog_key_i == PROG_KEY) state_d = PWR_UP;
            else begin
               err_d = 1'b1;
               nack  = 1'b1;
            end
         end
         PWR_UP:  if (pwr_last) state_d = din_q[a_q] ? PGM_BIT : SKIP;
         PGM_BIT: if (pgm_last) state_d = PGM_GAP;
         PGM_GAP, SKIP: if (last_bit) state_d = PWR_DN;
         else begin
            a_d     = a_inc;
            state_d = din_q[a_inc] ? PGM_BIT : SKIP;
         end
         PWR_DN:    if (pwr_last) state_d = DONE;
         RD_SETUP:  state_d = RD_STROBE;
         RD_STROBE: state_d = RD_CAP;
         RD_CAP: begin
            shadow_d[a_q] = bus.efuse_q_i;
            if (last_bit) begin
               state_d = DONE;
               dout_d  = shadow_d;
            end else begin
               a_d     = a_inc;
               state_d = RD_STROBE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort wins over any same-cycle bit transition but still runs the full discharge
      if (bus.abort_i && state_q inside {PWR_UP, PGM_BIT, PGM_GAP, SKIP}) begin
         state_d = PWR_DN;
         a_d     = a_q;
         err_d   = 1'b1;
      end
      if (state_d == DONE) a_d = '0;
      cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         din_q    <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         vddq_q   <= 1'b0;
         csb_q    <= 1'b1;
         pgm_q    <= 1'b0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         din_q    <= din_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         err_q    <= err_d;
         done_q   <= state_d == DONE || nack;
         vddq_q   <= state_d inside {PWR_UP, PGM_BIT, PGM_GAP, SKIP};
         csb_q    <= state_d inside {IDLE, DONE};
         pgm_q    <= state_d == PGM_BIT;
         strobe_q <= state_d == RD_STROBE;
         busy_q   <= state_d != IDLE;
      end
   end
   assign bus.efuse_vddq_en_o = vddq_q;
   assign bus.efuse_csb_o     = csb_q;
   assign bus.efuse_pgm_o     = pgm_q;
   assign bus.efuse_strobe_o  = strobe_q;
   assign bus.efuse_a_o       = a_q;
   assign bus.fuse_dout_o     = dout_q;
   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.err_o           = err_q;
endmodule

// File: tb/tb_efuse_prog_ctrl.sv
// tb_efuse_prog_ctrl: directed scenarios for the eFuse sequencer with hand-derived cycle counts.
module tb_efuse_prog_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   efuse_prog_ctrl_if #(.NBITS(32), .AW(5)) bus ();
   efuse_prog_ctrl #(.NBITS(32), .AW(5), .PGM_CYCLES(10), .PWR_CYCLES(4), .PROG_KEY(8'hA5)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus)
   );
   // macro model: sense data for the strobed address is valid the cycle after the strobe
   always @(posedge clk)
      if (bus.efuse_strobe_o) bus.efuse_q_i <= bus.efuse_a_o == 5'd0 || bus.efuse_a_o == 5'd31;
   always @(negedge clk) if (rst_n) begin
      checks++;
      if (bus.efuse_pgm_o && (!bus.efuse_vddq_en_o || bus.efuse_csb_o)) begin
         errors++;
         $display("FAIL inv_pgm: pgm=1 with vddq=%b csb=%b, want vddq=1 csb=0", bus.efuse_vddq_en_o, bus.efuse_csb_o);
      end
      checks++;
      if (bus.efuse_strobe_o && bus.efuse_vddq_en_o) begin
         errors++;
         $display("FAIL inv_strobe: strobe=1 with vddq=1, want not both");
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic kick(input logic pm, input logic [7:0] key, input logic [31:0] din);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.prog_mode_i = pm;
      bus.prog_key_i = key;
      bus.fuse_din_i = din;
      step();
      bus.start_i = 1'b0;
   endtask
   task automatic test_reset();
      bus.start_i = 0; bus.prog_mode_i = 0; bus.prog_key_i = 0; bus.abort_i = 0; bus.fuse_din_i = 0;
      rst_n = 1'b0;
      step(); step();
      checks++; if ({bus.efuse_vddq_en_o, bus.efuse_csb_o, bus.efuse_pgm_o, bus.efuse_strobe_o, bus.busy_o, bus.done_o, bus.err_o} !== 7'b0100000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0100000", {bus.efuse_vddq_en_o, bus.efuse_csb_o, bus.efuse_pgm_o, bus.efuse_strobe_o, bus.busy_o, bus.done_o, bus.err_o});
      end
      checks++; if (bus.efuse_a_o !== 5'd0) begin errors++; $display("FAIL reset_a: got %0d want 0", bus.efuse_a_o); end
      checks++; if (bus.fuse_dout_o !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.fuse_dout_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_prog();
      int first_pgm = 0, vddq_pre = 0, pgm0 = 0, pgm2 = 0, pgm_other = 0, done_n = 0, done_cnt = 0;
      logic err_at_done = 1'bx;
      kick(1'b1, 8'hA5, 32'h0000_0005);
      for (int n = 1; n <= 100; n++) begin
         if (bus.efuse_pgm_o) begin
            if (first_pgm == 0) first_pgm = n;
            if (bus.efuse_a_o == 5'd0) pgm0++;
            else if (bus.efuse_a_o == 5'd2) pgm2++;
            else pgm_other++;
         end else if (first_pgm == 0 && bus.efuse_vddq_en_o) vddq_pre++;
         if (bus.done_o) begin
            done_cnt++;
            if (done_n == 0) begin done_n = n; err_at_done = bus.err_o; end
         end
         step();
      end
      checks++; if (vddq_pre !== 4) begin errors++; $display("FAIL prog_vddq_settle: got %0d want 4", vddq_pre); end
      checks++; if (first_pgm !== 5) begin errors++; $display("FAIL prog_first_pgm: got %0d want 5", first_pgm); end
      checks++; if (pgm0 !== 10) begin errors++; $display("FAIL prog_pgm_a0: got %0d want 10", pgm0); end
      checks++; if (pgm2 !== 10) begin errors++; $display("FAIL prog_pgm_a2: got %0d want 10", pgm2); end
      checks++; if (pgm_other !== 0) begin errors++; $display("FAIL prog_pgm_other: got %0d want 0", pgm_other); end
      checks++; if (done_n !== 61) begin errors++; $display("FAIL prog_latency: got %0d want 61", done_n); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL prog_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL prog_err: got %b want 0", err_at_done); end
      checks++; if ({bus.busy_o, bus.efuse_csb_o, bus.efuse_a_o} !== 7'b0100000) begin errors++; $display("FAIL prog_idle: got %b want 0100000", {bus.busy_o, bus.efuse_csb_o, bus.efuse_a_o}); end
   endtask
   task automatic test_bad_key();
      int moved = 0, done_cnt = 0;
      logic first_done = 1'bx, first_err = 1'bx;
      kick(1'b1, 8'h5A, 32'hFFFF_FFFF);
      for (int n = 1; n <= 12; n++) begin
         if (n == 1) begin first_done = bus.done_o; first_err = bus.err_o; end
         if (bus.efuse_vddq_en_o || !bus.efuse_csb_o || bus.efuse_pgm_o || bus.busy_o || bus.efuse_strobe_o) moved++;
         if (bus.done_o) done_cnt++;
         step();
      end
      checks++; if (first_done !== 1'b1) begin errors++; $display("FAIL key_done: got %b want 1", first_done); end
      checks++; if (first_err !== 1'b1) begin errors++; $display("FAIL key_err: got %b want 1", first_err); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL key_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (moved !== 0) begin errors++; $display("FAIL key_moved: got %0d cycles want 0", moved); end
      checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL key_err_hold: got %b want 1", bus.err_o); end
   endtask
   task automatic test_read();
      int strobes = 0, double_strobe = 0, vddq_seen = 0, early = 0, done_n = 0;
      logic prev = 1'b0;
      logic [31:0] dout_done = 'x;
      kick(1'b0, 8'h00, 32'h0);
      for (int n = 1; n <= 90; n++) begin
         if (bus.efuse_strobe_o) begin strobes++; if (prev) double_strobe++; end
         prev = bus.efuse_strobe_o;
         if (bus.efuse_vddq_en_o) vddq_seen++;
         if (bus.done_o && done_n == 0) begin done_n = n; dout_done = bus.fuse_dout_o; end
         if (done_n == 0 && bus.fuse_dout_o !== 32'h0) early++;
         step();
      end
      checks++; if (strobes !== 32) begin errors++; $display("FAIL rd_strobes: got %0d want 32", strobes); end
      checks++; if (double_strobe !== 0) begin errors++; $display("FAIL rd_strobe_width: got %0d want 0", double_strobe); end
      checks++; if (vddq_seen !== 0) begin errors++; $display("FAIL rd_vddq: got %0d want 0", vddq_seen); end
      checks++; if (done_n !== 66) begin errors++; $display("FAIL rd_latency: got %0d want 66", done_n); end
      checks++; if (dout_done !== 32'h8000_0001) begin errors++; $display("FAIL rd_dout: got %h want 80000001", dout_done); end
      checks++; if (early !== 0) begin errors++; $display("FAIL rd_dout_early: got %0d want 0", early); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rd_err_clear: got %b want 0", bus.err_o); end
   endtask
   task automatic test_back_to_back();
      int busy_cnt = 0, done_cnt = 0, done_n = 0;
      kick(1'b0, 8'h00, 32'h0);
      for (int n = 1; n <= 100; n++) begin
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) begin done_cnt++; if (done_n == 0) done_n = n; end
         bus.start_i = n == 10 || n == 30 || n == 65;
         bus.prog_mode_i = n == 30;
         bus.prog_key_i = 8'hA5;
         step();
      end
      bus.start_i = 1'b0;
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (done_n !== 66) begin errors++; $display("FAIL b2b_latency: got %0d want 66", done_n); end
      checks++; if (busy_cnt !== 66) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 66", busy_cnt); end
   endtask
   task automatic test_abort();
      int discharge = 0, done_n = 0;
      logic [3:0] after = 'x;
      logic armed = 1'bx, csb_done = 1'bx, err_done = 1'bx;
      kick(1'b1, 8'hA5, 32'hFFFF_FFFF);
      for (int n = 1; n <= 70; n++) begin
         if (n == 40) armed = bus.efuse_pgm_o && bus.efuse_a_o == 5'd3;
         if (n == 41) after = {bus.efuse_pgm_o, bus.efuse_vddq_en_o, bus.efuse_csb_o, bus.err_o};
         if (!bus.efuse_vddq_en_o && !bus.efuse_csb_o) discharge++;
         if (bus.done_o && done_n == 0) begin done_n = n; csb_done = bus.efuse_csb_o; err_done = bus.err_o; end
         bus.abort_i = n == 40;
         step();
      end
      bus.abort_i = 1'b0;
      checks++; if (armed !== 1'b1) begin errors++; $display("FAIL abort_setup: pgm at a=3 got %b want 1", armed); end
      checks++; if (after !== 4'b0001) begin errors++; $display("FAIL abort_next_edge: pgm/vddq/csb/err got %b want 0001", after); end
      checks++; if (discharge !== 4) begin errors++; $display("FAIL abort_discharge: got %0d want 4", discharge); end
      checks++; if (done_n !== 45) begin errors++; $display("FAIL abort_done: got %0d want 45", done_n); end
      checks++; if (csb_done !== 1'b1) begin errors++; $display("FAIL abort_csb: got %b want 1", csb_done); end
      checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", err_done); end
   endtask
   task automatic test_reset_mid();
      logic in_pgm;
      kick(1'b1, 8'hA5, 32'h0000_0001);
      for (int n = 1; n < 8; n++) step();
      in_pgm = bus.efuse_pgm_o;
      rst_n = 1'b0;
      #1;
      checks++; if (in_pgm !== 1'b1) begin errors++; $display("FAIL rst_setup: pgm got %b want 1", in_pgm); end
      checks++; if ({bus.efuse_vddq_en_o, bus.efuse_pgm_o, bus.efuse_csb_o, bus.busy_o} !== 4'b0010) begin
         errors++; $display("FAIL rst_async: vddq/pgm/csb/busy got %b want 0010", {bus.efuse_vddq_en_o, bus.efuse_pgm_o, bus.efuse_csb_o, bus.busy_o});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      test_reset();
      test_prog();
      test_bad_key();
      test_read();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
